// File: rtl/decoder_n_scan_pkg.sv
// Shared definitions for the N-to-2^N decoder with scan sequencer:
// mode encodings and the sequencer state type.
package decoder_n_scan_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SWEEP = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_n_scan_onehot_decode.sv
// Purely combinational N -> 2^N one-hot decoder, shared by the direct
// decode path and the scan sequencer.
module onehot_decode #(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel,
    output logic [(1<<N)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/decoder_n_scan.sv
// N-to-2^N registered one-hot decoder with a built-in scan/sweep sequencer
// that steps the active output through every channel with a programmable dwell.
module decoder_n_scan
    import decoder_n_scan_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       i,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               start,
    input  logic               stop,
    output logic [(1<<N)-1:0]  d,
    output logic [N-1:0]       idx,
    output logic               busy,
    output logic               done
);

    state_t             state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_lat;
    logic [N-1:0]       dec_sel;
    logic [(1<<N)-1:0]  dec_out;
    logic               running;
    logic               step;
    logic               last;
    logic               start_ok;

    assign running  = (state != IDLE);
    assign step     = running && en && (dwell_cnt == '0);
    assign last     = &idx;
    assign start_ok = start && en && !stop &&
                      ((mode == MODE_SCAN) || (mode == MODE_SWEEP));

    // One decoder serves both paths: the raw select while idle in direct
    // mode, channel 0 when a scan launches, otherwise the current/next index.
    always_comb begin
        dec_sel = idx;
        if (!running) begin
            dec_sel = (mode == MODE_DIRECT) ? i : '0;
        end else if (step) begin
            dec_sel = idx + N'(1);
        end
    end

    onehot_decode #(.N(N)) u_dec (
        .sel    (dec_sel),
        .onehot (dec_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            d         <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
            dwell_lat <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_ok) begin
                        state     <= (mode == MODE_SCAN) ? SCAN : SWEEP;
                        idx       <= '0;
                        d         <= dec_out;
                        busy      <= 1'b1;
                        dwell_cnt <= dwell;
                        dwell_lat <= dwell;
                    end else if (mode == MODE_DIRECT) begin
                        d   <= en ? dec_out : '0;
                        idx <= i;
                    end else begin
                        d   <= '0;
                        idx <= '0;
                    end
                end
                SCAN, SWEEP: begin
                    // A low enable holds index, counter and state; only d blanks.
                    if (stop) begin
                        state <= IDLE;
                        d     <= '0;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else if (!en) begin
                        d <= '0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        d         <= dec_out;
                    end else if ((state == SWEEP) && last) begin
                        state <= IDLE;
                        d     <= '0;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx       <= dec_sel;
                        dwell_cnt <= dwell_lat;
                        d         <= dec_out;
                    end
                end
                default: begin
                    state <= IDLE;
                    d     <= '0;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Self-checking bench for decoder_n_scan: directed scenarios plus random
// stimulus, compared against a time-based reference model.
module tb_decoder_n_scan;
    import decoder_n_scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, start, stop;
    logic [1:0] mode;
    logic [2:0] i;
    logic [7:0] dwell;
    logic [7:0] d;
    logic [2:0] idx;
    logic       busy, done;

    logic        en4;
    logic [3:0]  i4;
    logic [15:0] d4;
    logic [3:0]  idx4;
    logic        busy4, done4;

    decoder_n_scan #(.N(3), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .i(i), .dwell(dwell),
        .start(start), .stop(stop), .d(d), .idx(idx), .busy(busy), .done(done)
    );

    decoder_n_scan #(.N(4), .DWELL_W(8)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .mode(MODE_DIRECT), .i(i4), .dwell(8'd0),
        .start(1'b0), .stop(1'b0), .d(d4), .idx(idx4), .busy(busy4), .done(done4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: channel is derived from the number of enabled cycles
    // elapsed since launch, divided by the per-channel hold time.
    bit         m_active, m_sweep;
    int         m_dwell, m_t;
    logic [7:0] e_d;
    int         e_idx;
    bit         e_busy, e_done;

    int busy_cycles, done_cycles;
    int ch_cycles[8];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep();
        if (rst) begin
            m_active = 0; m_t = 0;
            e_d = 8'h0; e_idx = 0; e_busy = 0; e_done = 0;
        end else begin
            e_done = 0;
            if (!m_active) begin
                if (start && en && !stop && (mode == 2'b01 || mode == 2'b10)) begin
                    m_active = 1; m_sweep = (mode == 2'b10);
                    m_dwell = int'(dwell); m_t = 0;
                    e_idx = 0; e_d = 8'h01; e_busy = 1;
                end else if (mode == 2'b00) begin
                    e_idx = int'(i); e_d = en ? 8'(32'd1 << i) : 8'h0; e_busy = 0;
                end else begin
                    e_idx = 0; e_d = 8'h0; e_busy = 0;
                end
            end else if (stop) begin
                m_active = 0; e_d = 8'h0; e_idx = 0; e_busy = 0;
            end else if (!en) begin
                e_d = 8'h0;
            end else begin
                m_t++;
                if (m_sweep && m_t == 8 * (m_dwell + 1)) begin
                    m_active = 0; e_d = 8'h0; e_idx = 0; e_busy = 0; e_done = 1;
                end else begin
                    e_idx = (m_t / (m_dwell + 1)) % 8;
                    e_d = 8'(32'd1 << e_idx);
                end
            end
        end
    endtask

    task automatic resetStats();
        busy_cycles = 0; done_cycles = 0;
        for (int j = 0; j < 8; j++) ch_cycles[j] = 0;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic [2:0] sel, input logic [7:0] dw,
                                 input logic st, input logic sp);
        @(negedge clk);
        rst = r; en = e; mode = m; i = sel; dwell = dw; start = st; stop = sp;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("d", 32'(d), 32'(e_d));
        checkOutput("idx", 32'(idx), e_idx);
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("done", 32'(done), 32'(e_done));
        checkOutput("busy_and_done", 32'(busy & done), 32'h0);
        if (busy) busy_cycles++;
        if (done) done_cycles++;
        for (int j = 0; j < 8; j++) if (d == 8'(32'd1 << j)) ch_cycles[j]++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; i = 3'd0; dwell = 8'd0;
        start = 1'b0; stop = 1'b0; en4 = 1'b0; i4 = 4'd0;
        resetStats();

        applyStimulus(1'b1, 1'b0, MODE_DIRECT, 3'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("rst_d", 32'(d), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, MODE_DIRECT, k[2:0], 8'd0, 1'b0, 1'b0);
            checkOutput("dir_d", 32'(d), 32'd1 << k);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, MODE_DIRECT, k[2:0], 8'd0, 1'b0, 1'b0);
            checkOutput("dir_en0_d", 32'(d), 32'h0);
        end

        for (int k = 0; k < 32; k++) begin
            en4 = (k < 16); i4 = k[3:0];
            applyStimulus(1'b0, 1'b0, MODE_DIRECT, 3'd0, 8'd0, 1'b0, 1'b0);
            checkOutput("dir4_d", 32'(d4), (k < 16) ? (32'd1 << k[3:0]) : 32'h0);
            checkOutput("dir4_idx", 32'(idx4), 32'(k[3:0]));
            checkOutput("dir4_busy", 32'(busy4 | done4), 32'h0);
        end

        // Sweep with dwell 2, with mode/dwell change and re-start mid-sweep.
        resetStats();
        applyStimulus(1'b0, 1'b1, MODE_SWEEP, 3'd0, 8'd2, 1'b1, 1'b0);
        for (int k = 0; k < 26; k++) begin
            if (k == 5) applyStimulus(1'b0, 1'b1, MODE_DIRECT, 3'd3, 8'd7, 1'b1, 1'b0);
            else        applyStimulus(1'b0, 1'b1, (k > 5) ? MODE_SCAN : MODE_SWEEP, 3'd0, 8'd2, 1'b0, 1'b0);
        end
        checkOutput("sweep_busy_cycles", busy_cycles, 24);
        checkOutput("sweep_done_cycles", done_cycles, 1);
        for (int j = 0; j < 8; j++) checkOutput("sweep_ch_cycles", ch_cycles[j], 3);

        // Continuous scan, dwell 0, then stop.
        resetStats();
        applyStimulus(1'b0, 1'b1, MODE_SCAN, 3'd0, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++)
            applyStimulus(1'b0, 1'b1, MODE_SCAN, 3'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("scan_done_cycles", done_cycles, 0);
        checkOutput("scan_busy_cycles", busy_cycles, 11);
        checkOutput("scan_wrap_ch0", ch_cycles[0], 2);
        checkOutput("scan_ch7", ch_cycles[7], 1);
        applyStimulus(1'b0, 1'b1, MODE_SCAN, 3'd0, 8'd0, 1'b0, 1'b1);
        checkOutput("stop_d", 32'(d), 32'h0);
        checkOutput("stop_idx", 32'(idx), 32'h0);
        checkOutput("stop_busy", 32'(busy), 32'h0);

        // Freeze on channel 2 mid-dwell.
        resetStats();
        applyStimulus(1'b0, 1'b1, MODE_SWEEP, 3'd0, 8'd3, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++)
            applyStimulus(1'b0, 1'b1, MODE_SWEEP, 3'd0, 8'd3, 1'b0, 1'b0);
        checkOutput("pre_freeze_idx", 32'(idx), 32'd2);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, MODE_SWEEP, 3'd0, 8'd3, 1'b0, 1'b0);
            checkOutput("freeze_d", 32'(d), 32'h0);
            checkOutput("freeze_idx", 32'(idx), 32'd2);
        end
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b1, MODE_SWEEP, 3'd0, 8'd3, 1'b0, 1'b0);
        checkOutput("freeze_ch2_cycles", ch_cycles[2], 4);
        checkOutput("post_freeze_idx", 32'(idx), 32'd3);
        applyStimulus(1'b0, 1'b1, MODE_SWEEP, 3'd0, 8'd3, 1'b0, 1'b1);

        // Launch attempts that must be ignored.
        applyStimulus(1'b0, 1'b0, MODE_SWEEP, 3'd0, 8'd1, 1'b1, 1'b0);
        checkOutput("start_en0_busy", 32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b1, MODE_SCAN, 3'd0, 8'd1, 1'b1, 1'b1);
        checkOutput("start_stop_busy", 32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b1, MODE_RSVD, 3'd0, 8'd1, 1'b1, 1'b0);
        checkOutput("rsvd_d", 32'(d), 32'h0);
        checkOutput("rsvd_busy", 32'(busy), 32'h0);

        // Reset mid-scan at channel 5, then direct decode.
        applyStimulus(1'b0, 1'b1, MODE_SCAN, 3'd0, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b0, 1'b1, MODE_SCAN, 3'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("pre_rst_idx", 32'(idx), 32'd5);
        applyStimulus(1'b1, 1'b1, MODE_DIRECT, 3'd3, 8'd0, 1'b0, 1'b0);
        checkOutput("mid_rst_d", 32'(d), 32'h0);
        checkOutput("mid_rst_busy", 32'(busy | done), 32'h0);
        applyStimulus(1'b0, 1'b1, MODE_DIRECT, 3'd3, 8'd0, 1'b0, 1'b0);
        checkOutput("post_rst_d", 32'(d), 32'h08);

        for (int k = 0; k < 1500; k++) begin
            applyStimulus(1'($urandom_range(0, 199) == 0),
                          1'($urandom_range(0, 9) != 0),
                          2'($urandom_range(0, 3)),
                          3'($urandom),
                          8'($urandom_range(0, 3)),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_n_scan.md
Name: decoder_n_scan

Overview:
Parametrised successor to the 3-to-8 decoder: an N-to-2^N one-hot decoder with registered outputs and an enable, plus a built-in scan sequencer. The sequencer steps the active output through all 2^N channels with a programmable dwell time, either continuously or as a single sweep. It is used for row/column strobing and channel-select sequencing.

Parameters:
N, 3, select width; output width is 2^N.
DWELL_W, 8, width of the dwell-count input.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-high.
en  in  1  output enable; low forces d to 0 and freezes the sequencer.
mode  in  2  00 direct decode, 01 continuous scan, 10 single sweep, 11 reserved.
i  in  N  select input, direct mode only.
dwell  in  DWELL_W  extra cycles per channel; each channel is held dwell+1 cycles.
start  in  1  single-cycle pulse; begins a scan/sweep in mode 01/10.
stop  in  1  single-cycle pulse; aborts a scan/sweep.
d  out  2^N  registered one-hot output (all-zero when inactive).
idx  out  N  index of the currently active channel.
busy  out  1  high while scanning/sweeping.
done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; d=0, idx=0, busy=0, done=0, dwell counter=0. Reset has priority over all inputs, including mid-scan.
- All outputs are registered. Latency is 1 cycle from input to d.
- FSM states are IDLE, SCAN (continuous) and SWEEP (single).
- IDLE with mode=00:
  - d <= en ? (1<<i) : 0.
  - idx <= i.
  - busy=0.
- IDLE with mode=11: d <= 0. start is ignored.
- IDLE, mode in {01,10}, start=1, en=1, stop=0:
  - Next cycle: state SCAN (01) or SWEEP (10), idx=0, d=8'h01 (for N=3), busy=1.
  - Dwell counter is loaded with dwell, and dwell is latched at this point.
  - mode is latched at start; later mode/dwell/i changes are ignored until the FSM returns to IDLE.
- start with en=0 is ignored.
- SCAN/SWEEP, en=1:
  - Counter nonzero: decrement it.
  - Counter zero: advance idx, reload the counter with the latched dwell, and set d <= 1<<idx_next.
  - dwell=0 advances every cycle.
- SCAN wrap: idx 2^N-1 -> 0, running indefinitely.
- SWEEP end: when idx=2^N-1 and the counter is 0, next cycle goes to IDLE with d=0, busy=0, done=1 for exactly one cycle, and idx=0.
- en=0 in SCAN/SWEEP:
  - d <= 0.
  - idx, counter and state are held.
  - When en returns to 1, d <= 1<<idx next cycle and dwell counting resumes from the held value. The frozen cycles do not count.
- stop=1 in SCAN/SWEEP:
  - Next cycle: IDLE, d=0, busy=0, idx=0, and no done pulse.
  - stop together with start: stop wins.
  - stop in IDLE has no effect.
- start while busy is ignored (no restart).
- Invariants:
  - d is always either 0 or exactly one-hot.
  - When d≠0, d == 1<<idx.
  - done and busy are never high in the same cycle.

Decomposition:
- Shared package holds:
  - mode encodings MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_SWEEP=2'b10, MODE_RSVD=2'b11;
  - the FSM state typedef (IDLE/SCAN/SWEEP).
- One natural sub-module: onehot_decode (purely combinational N -> 2^N decode, parametrised on N), shared by the direct path and the scan path.
- FSM, idx counter and dwell counter stay in the top module.

Test Plan:
- Direct, N=3, en=1, sweep i=0..7 -> d one cycle later = 01,02,04,...,80; with en=0, d=00 for all i. Repeat for N=4 (i=15 -> d=16'h8000).
- Sweep, mode=10, dwell=2, start pulse -> each bit of d high 3 cycles, from 01 to 80 (24 cycles busy); then d=00, busy=0, done=1 for exactly 1 cycle.
- Scan, mode=01, dwell=0 -> d=01,02,...,80,01 on consecutive cycles (wrap); busy stays 1 and done never pulses; stop -> next cycle d=00, idx=0, busy=0.
- Freeze, mode=10, dwell=3: drop en for 5 cycles while idx=2 mid-dwell -> d=00 and idx=2 during the freeze; on resume, d=04 for the remaining dwell cycles only (total 4 enabled cycles on channel 2).
- Boundaries:
  - start with en=0 -> ignored;
  - start+stop same cycle -> remains IDLE;
  - start while busy -> no restart;
  - mode/dwell changed mid-sweep -> no effect;
  - mode=11 + start -> d=00, busy=0.
- Reset mid-scan at idx=5 -> next cycle d=00, idx=0, busy=0, done=0; direct decode is valid from the following cycle.
